vector_packer: RTL and testbench

- Serial-to-parallel packer directly upstream of the elastic vector register.
- Accepts one width_p-bit element per handshake and assembles depth_p of them into one lane vector.
- Presents the vector with valid/ready so it can feed the elastic stage's data_i/valid_i/ready_o unchanged.
- Supports early termination: a last marker zero-pads the remaining lanes.

---
 rtl/vector_packer_pkg.sv | 20 ++
 rtl/vector_packer.sv | 110 +++++++++++
 tb/tb_vector_packer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_packer_pkg.sv
// Shared types and width helpers for the vector packer and its consumers.
package vector_packer_pkg;

    // Packer state: FILL while assembling lanes, FULL while a vector is on offer.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Width of an index counter over n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Width of a population count able to represent 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vector_packer.sv
// Serial-to-parallel packer: gathers depth_p elements (or fewer, closed by
// last_i) into one zero-padded lane vector offered with valid/ready.
module vector_packer
    import vector_packer_pkg::*;
#(
    parameter int width_p = 8,
    parameter int depth_p = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [width_p-1:0]                data_i,
    input  logic                              valid_i,
    input  logic                              last_i,
    output logic                              ready_o,
    output logic                              valid_o,
    output logic [width_p-1:0]                data_o [depth_p-1:0],
    output logic [count_width(depth_p)-1:0]   count_o,
    output logic                              last_o,
    input  logic                              ready_i
);

    localparam int idx_w_lp = idx_width(depth_p);
    localparam int cnt_w_lp = count_width(depth_p);
    localparam logic [idx_w_lp-1:0] idx_max_lp = idx_w_lp'(depth_p - 1);

    state_e              state;
    logic [idx_w_lp-1:0] idx;
    logic                in_fire;
    logic                out_fire;
    logic                fill_close;
    logic                pass_close;

    assign valid_o  = (state == FULL);
    // Backpressure is purely downstream-driven so it never depends on valid_i.
    assign ready_o  = ~valid_o | ready_i;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    // Element lands in lane idx while filling; lane 0 on a pass-through.
    assign fill_close = (idx == idx_max_lp) | last_i;
    assign pass_close = (depth_p == 1) | last_i;

    // Lane array: write the accepted element, clear all lanes on emission.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < depth_p; i++) begin
            // NOTE: lanes are reset because zero-padding of early-closed vectors relies on cleared storage.
            if (rst_i) begin
                data_o[i] <= '0;
            end else if (state == FILL) begin
                if (in_fire && idx == idx_w_lp'(i)) begin
                    data_o[i] <= data_i;
                end
            end else if (out_fire) begin
                data_o[i] <= (i == 0 && in_fire) ? data_i : '0;
            end
        end
    end

    // Control: write index, FILL/FULL state, populated-lane count and last flag.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values, independent of statement order.
        if (rst_i) begin
            state   <= FILL;
            idx     <= '0;
            count_o <= '0;
            last_o  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        count_o <= cnt_w_lp'(idx) + cnt_w_lp'(1);
                        if (fill_close) begin
                            state  <= FULL;
                            last_o <= last_i;
                            idx    <= '0;
                        end else begin
                            idx <= idx + idx_w_lp'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            // Pass-through: new element becomes lane 0 of the next vector.
                            count_o <= cnt_w_lp'(1);
                            if (pass_close) begin
                                last_o <= last_i;
                                idx    <= '0;
                            end else begin
                                state  <= FILL;
                                last_o <= 1'b0;
                                idx    <= idx_w_lp'(1);
                            end
                        end else begin
                            state   <= FILL;
                            count_o <= '0;
                            last_o  <= 1'b0;
                            idx     <= '0;
                        end
                    end
                end
                default: begin
                    state <= FILL;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_packer.sv
// Self-checking bench: depth 4 and depth 1 packers against a queue-style model.
module tb_vector_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    logic       rdy4, val4, lst4;
    logic [7:0] d4 [3:0];
    logic [2:0] cnt4;

    logic       rdy1, val1, lst1;
    logic [7:0] d1 [0:0];
    logic [0:0] cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_packer #(.width_p(8), .depth_p(4)) u4 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .last_i(last),
        .ready_o(rdy4), .valid_o(val4), .data_o(d4), .count_o(cnt4), .last_o(lst4),
        .ready_i(ready)
    );

    vector_packer #(.width_p(8), .depth_p(1)) u1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .last_i(last),
        .ready_o(rdy1), .valid_o(val1), .data_o(d1), .count_o(cnt1), .last_o(lst1),
        .ready_i(ready)
    );

    // Model: elements collected so far, plus the vector currently shown.
    typedef struct packed {
        logic            valid;
        logic            last;
        logic [2:0]      count;
        logic [2:0]      cur_n;
        logic [3:0][7:0] cur;
        logic [3:0][7:0] lanes;
    } model_t;

    model_t m4 = '0;
    model_t m1 = '0;

    function automatic model_t step(model_t m, int depth, logic r, logic vi,
                                    logic [7:0] di, logic li, logic ri);
        model_t n = m;
        logic in_f, out_f;
        if (r) return '0;
        in_f  = vi && (!m.valid || ri);
        out_f = m.valid && ri;
        if (out_f) begin
            n.valid = 1'b0;
            n.last  = 1'b0;
            n.count = '0;
            n.lanes = '0;
        end
        if (in_f) begin
            n.cur[n.cur_n] = di;
            n.cur_n = n.cur_n + 3'd1;
            n.lanes = n.cur;
            n.count = n.cur_n;
            if (int'(n.cur_n) == depth || li) begin
                n.valid = 1'b1;
                n.last  = li;
                n.cur   = '0;
                n.cur_n = '0;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on each edge; outputs are compared shortly after it.
    always @(posedge clk) begin
        m4 = step(m4, 4, rst, valid, data, last, ready);
        m1 = step(m1, 1, rst, valid, data, last, ready);
        #2;
        check("d4_ready", 32'(rdy4), 32'(!m4.valid || ready));
        check("d4_valid", 32'(val4), 32'(m4.valid));
        check("d4_count", 32'(cnt4), 32'(m4.count));
        check("d4_last",  32'(lst4), 32'(m4.last));
        for (int i = 0; i < 4; i++) check("d4_lane", 32'(d4[i]), 32'(m4.lanes[i]));
        check("d1_ready", 32'(rdy1), 32'(!m1.valid || ready));
        check("d1_valid", 32'(val1), 32'(m1.valid));
        check("d1_count", 32'(cnt1), 32'(m1.count));
        check("d1_last",  32'(lst1), 32'(m1.last));
        check("d1_lane0", 32'(d1[0]), 32'(m1.lanes[0]));
    end

    task automatic push(input logic [7:0] d, input logic l);
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        last  = l;
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid = 1'b0;
            last  = 1'b0;
            @(posedge clk);
            #3;
        end
    endtask

    task automatic check_vec4(input string name, input logic [31:0] lanes,
                              input int cnt, input logic lst, input logic vld);
        check({name, "_valid"}, 32'(val4), 32'(vld));
        check({name, "_count"}, 32'(cnt4), 32'(cnt));
        check({name, "_last"},  32'(lst4), 32'(lst));
        check({name, "_lanes"}, {d4[3], d4[2], d4[1], d4[0]}, lanes);
    endtask

    initial begin
        rst   = 1'b1;
        data  = '0;
        valid = 1'b0;
        last  = 1'b0;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check_vec4("reset", 32'h0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full vector
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
        check("full_ready_mid", 32'(rdy4), 32'd1);
        push(8'h44, 0);
        check_vec4("full", 32'h44332211, 4, 1'b0, 1'b1);
        check("full_ready", 32'(rdy4), 32'd1);
        idle(1);

        // Early last
        push(8'hA1, 0); push(8'hA2, 1);
        check_vec4("early", 32'h0000A2A1, 2, 1'b1, 1'b1);
        idle(1);

        // Backpressure then pass-through
        @(negedge clk);
        ready = 1'b0;
        push(8'hB1, 0); push(8'hB2, 0); push(8'hB3, 0); push(8'hB4, 0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("bp_ready", 32'(rdy4), 32'd0);
            check_vec4("bp_hold", 32'hB4B3B2B1, 4, 1'b0, 1'b1);
        end
        @(negedge clk);
        ready = 1'b1;
        push(8'h55, 0);
        check_vec4("pass", 32'h00000055, 1, 1'b0, 1'b0);
        push(8'h66, 0); push(8'h77, 0); push(8'h88, 0);
        check_vec4("pass_close", 32'h88776655, 4, 1'b0, 1'b1);

        // Streaming 0x01..0x0C back to back
        for (int i = 1; i <= 12; i++) begin
            push(8'(i), 0);
            check("stream_ready", 32'(rdy4), 32'd1);
            if (i == 4) check_vec4("stream_v0", 32'h04030201, 4, 1'b0, 1'b1);
            if (i == 12) check_vec4("stream_v2", 32'h0C0B0A09, 4, 1'b0, 1'b1);
            check("d1_stream_valid", 32'(val1), 32'd1);
        end
        check("d1_stream_lane0", 32'(d1[0]), 32'h0C);
        check("d1_stream_count", 32'(cnt1), 32'd1);
        idle(1);

        // Reset mid-fill
        push(8'h01, 0); push(8'h02, 0);
        @(negedge clk);
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #3;
        check_vec4("rst_during", 32'h0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #3;
        check_vec4("rst_after", 32'h0, 0, 1'b0, 1'b0);
        push(8'h03, 0); push(8'h04, 0); push(8'h05, 0); push(8'h06, 0);
        check_vec4("rst_vec", 32'h06050403, 4, 1'b0, 1'b1);
        idle(1);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 299) == 0);
            valid = ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
            last  = ($urandom_range(0, 7) == 0);
            ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
